load_store_unit: RTL
====================

# load_store_unit

CPU-side initiator for the data-memory bus. Takes one RV32I load/store request at a time from the execute stage and drives `mem_addr`, `mem_sdata`, `mem_mask` and `mem_lenable` toward the synchronous data memory. It performs byte-lane steering on stores and extraction/sign-extension on loads. It returns one response per request to writeback.

## Interface
- `LOAD_LATENCY`, 1: clock edges from the edge that samples `mem_lenable` to `mem_ldata` being valid; legal range 1–7.
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `req_rd`  in  5  destination register, echoed on the response
- `resp_valid`  out  1  one-cycle response pulse; no backpressure
- `resp_data`  out  32  formatted load data; 0 for stores
- `resp_rd`  out  5  echoed `req_rd`
- `resp_fault`  out  1  misaligned access, qualified by `resp_valid`
- `mem_addr`  out  32  registered address, byte granular
- `mem_sdata`  out  32  lane-replicated store data
- `mem_mask`  out  4  byte write enables; nonzero for exactly one cycle per store
- `mem_lenable`  out  1  load strobe; high for exactly one cycle per load
- `mem_ldata`  in  32  word read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register the whole request and go to ISSUE.
- ISSUE, store: drive `mem_mask` for one cycle, then go to RESP.
  - SB: `mem_sdata`={4{wdata[7:0]}}, mask=0001<<addr[1:0].
  - SH: `mem_sdata`={2{wdata[15:0]}}, mask=0011<<(2·addr[1]).
  - SW: mask=1111.
- ISSUE, load: `mem_lenable`=1 for one cycle, then go to WAIT.
- WAIT: a 3-bit counter runs for LOAD_LATENCY cycles. On the last WAIT cycle, sample `mem_ldata` and go to RESP.
  - The sampled word is shifted right by 8·addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- Unused funct3 codes: 011/110/111 on loads behave as LW; any code other than 000/001 on stores behaves as SW.
- `mem_addr` holds the registered `req_addr` from ISSUE until the next accept. Bits [1:0] are passed through unchanged.
- Outside ISSUE, `mem_mask`=0 and `mem_lenable`=0.

## Timing
- Request accepted on edge T. ISSUE is cycle T+1.
- Store: `resp_valid` is asserted in cycle T+2.
- Load: `resp_valid` is asserted in cycle T+2+LOAD_LATENCY (T+3 by default).
- Throughput: one request per 3 cycles for stores and per 3+LOAD_LATENCY cycles for loads. Back-to-back requests are accepted the cycle after RESP.
- Reset (`rst`=0), applied immediately and asynchronously:
  - state = IDLE, counter = 0, `req_ready`=1;
  - `resp_valid`, `resp_fault`, `mem_mask`, `mem_lenable` = 0;
  - `resp_data`, `resp_rd`, `mem_addr`, `mem_sdata` = 0.
- While `rst`=0, `req_valid` is ignored.
- Reset mid-operation aborts the access. No response is produced. A pending load's returning data is discarded.
- `req_*` inputs are don't-care when not handshaking.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, goes IDLE→RESP directly.
  - No memory strobes are issued.
  - `resp_fault`=1 and `resp_data`=0; response in cycle T+1.
- Undefined:
  - Misaligned addresses are force-aligned for lane selection: H clears addr[0]; W clears addr[1:0].
  - The access proceeds normally.
  - `resp_fault` is tied to 0.

## Test plan
- Store SB: addr 0x103, wdata 0x000000A5 → one cycle with `mem_mask`=1000 and `mem_sdata`=0xA5A5A5A5; `resp_valid` at T+2.
- Load LH then LHU: addr 0x102, memory word 0x8001_7FFF → `resp_data`=0xFFFF8001, then 0x00008001; `resp_valid` at T+3.
- Load LB: addr 0x101, word 0x0000_8000 → `resp_data`=0xFFFFFF80; `resp_rd` echoes 5'd17.
- Misaligned LW at 0x102:
  - with macro → `resp_fault`=1, `resp_data`=0, `mem_lenable` never asserted;
  - without macro → `mem_lenable` pulse, full word returned, fault=0.
- Reset asserted during WAIT → all outputs 0 immediately; no `resp_valid`. A new LW after release completes normally.
- LOAD_LATENCY=3, back-to-back SW then LW with `req_valid` held high → second accept occurs the cycle after the first RESP; load response at T+5.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute/writeback request-response and data-memory bus bundle for the load/store unit
//   slave  : the load_store_unit side (takes requests, drives responses and memory strobes)
//   master : the CPU/memory side (drives requests and read data)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [3:0]  mem_mask;
  logic        mem_lenable;
  logic [31:0] mem_ldata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_ldata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault,
           mem_addr, mem_sdata, mem_mask, mem_lenable
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_ldata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault,
           mem_addr, mem_sdata, mem_mask, mem_lenable
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with store lane steering and load extraction
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (req_*, resp_*, mem_*)
//   LOAD_LATENCY (1-7): edges from the lenable-sampling edge to valid mem_ldata
//   Macro LSU_MISALIGN_TRAP_EN: misaligned H/W requests answer with resp_fault instead of force-aligning
module load_store_unit #(
  parameter int LOAD_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [2:0] LAST = 3'(LOAD_LATENCY - 1);
  state_t state;
  logic [2:0] cnt;
  logic r_we, r_b, r_h, r_sx;
  logic in_b, in_h, trap;
  logic [3:0] st_mask;
  logic [31:0] st_data, sh, ld;
  logic [1:0] lane;
  // byte/half decode differs by direction: 100/101 are BU/HU on loads but SW on stores
  assign in_b = bus.req_we ? bus.req_funct3 == 3'b000 : bus.req_funct3[1:0] == 2'b00;
  assign in_h = bus.req_we ? bus.req_funct3 == 3'b001 : bus.req_funct3[1:0] == 2'b01;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = in_h ? bus.req_addr[0] : !in_b && bus.req_addr[1:0] != 2'b00;
`else
  assign trap = 1'b0;
`endif
  assign st_mask = in_b ? 4'b0001 << bus.req_addr[1:0] : in_h ? 4'b0011 << {bus.req_addr[1], 1'b0} : 4'b1111;
  assign st_data = in_b ? {4{bus.req_wdata[7:0]}} : in_h ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  // lane selection ignores the low address bits a halfword/word cannot use (force alignment)
  assign lane = r_b ? bus.mem_addr[1:0] : r_h ? {bus.mem_addr[1], 1'b0} : 2'b00;
  assign sh = bus.mem_ldata >> {lane, 3'b000};
  assign ld = r_b ? {{24{r_sx & sh[7]}}, sh[7:0]} : r_h ? {{16{r_sx & sh[15]}}, sh[15:0]} : sh;
  assign bus.req_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      {r_we, r_b, r_h, r_sx} <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_data <= '0;
      bus.resp_rd <= '0;
      bus.mem_addr <= '0;
      bus.mem_sdata <= '0;
      bus.mem_mask <= '0;
      bus.mem_lenable <= 1'b0;
    end else begin
      bus.mem_mask <= '0;
      bus.mem_lenable <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.mem_addr <= bus.req_addr;
          bus.mem_sdata <= st_data;
          bus.resp_rd <= bus.req_rd;
          bus.resp_data <= '0;
          bus.resp_fault <= trap;
          {r_we, r_b, r_h, r_sx} <= {bus.req_we, in_b, in_h, !bus.req_funct3[2]};
          // strobes are registered here so they appear exactly in the ISSUE cycle
          bus.mem_mask <= bus.req_we && !trap ? st_mask : 4'b0000;
          bus.mem_lenable <= !bus.req_we && !trap;
          bus.resp_valid <= trap;
          state <= trap ? RESP : ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          bus.resp_valid <= r_we;
          state <= r_we ? RESP : WAIT;
        end
        WAIT: if (cnt == LAST) begin
          bus.resp_data <= ld;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt + 3'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
